vec_stream_serializer: RTL and testbench
========================================

// Module: vec_stream_serializer
// PURPOSE
//   Transmit side of the layer input stream. Accepts one N-element signed vector per
//   handshake on a parallel port and emits its elements one per handshake on the
//   s_valid/s_ready-style serial stream that feeds layer_* blocks.
//   Two vector slots (ping-pong): the next vector loads while the current one drains,
//   so a ready consumer sees no bubbles between vectors.
// PARAMETERS
//   T  16  element width in bits, signed
//   N  4   elements per vector
// PORTS
//   clk       in   1    clock, all state updates on posedge
//   reset_n   in   1    asynchronous, active-low reset
//   in_valid  in   1    producer has a vector on in_vec
//   in_ready  out  1    block can accept a vector this cycle
//   in_vec    in   N*T  vector; element k = in_vec[k*T +: T]; element 0 is sent first
//   m_valid   out  1    data_out holds a valid element
//   m_ready   in   1    downstream (layer s_ready) accepts the element
//   data_out  out  T    current element, signed
//   m_last    out  1    current element is element N-1 of its vector
// BEHAVIOUR
//   - State: slot[0..1] (N*T bits each), full[0..1], wr_sel, rd_sel, idx (0..N-1).
//     Occupancy FSM: EMPTY (0 full) -> ONE (1 full) -> TWO (2 full).
//   - Reset (reset_n=0, any time, including mid-vector): full=0, wr_sel=rd_sel=0, idx=0,
//     m_valid=0, m_last=0, data_out=0, in_ready=0. A partially sent vector is discarded.
//     in_ready=1 in the first cycle after reset_n deasserts. Slot contents are not reset.
//   - in_ready = ~full[wr_sel], decoded from registers only. It has no combinational
//     path from m_ready or in_valid.
//   - Accept: in_valid & in_ready at a posedge -> slot[wr_sel]<=in_vec, full[wr_sel]<=1,
//     wr_sel toggles. in_vec is sampled only on that edge.
//   - m_valid = full[rd_sel]; data_out = slot[rd_sel][idx*T +: T] when m_valid=1, else 0.
//     m_last = m_valid & (idx==N-1). All outputs are decoded from registers.
//   - Send: m_valid & m_ready at a posedge -> if idx<N-1, idx++. Else idx<=0,
//     full[rd_sel]<=0, rd_sel toggles.
//   - m_valid=1 & m_ready=0: data_out, m_last and idx are held stable (no retraction).
//   - Latency: a vector accepted at edge k in EMPTY gives m_valid=1, element 0 in cycle k+1.
//     An uninterrupted drain is N cycles per vector. Back-to-back vectors have zero gap
//     when the next vector was loaded into the other slot before the last element left.
//   - Same-edge accept and final-element send: both take effect. They touch different
//     slots, so occupancy is unchanged. In TWO, in_ready stays 0 in that cycle; there is
//     no bypass, and in_ready rises the next cycle.
//   - Sustained rate: 1 element/cycle downstream, 1 vector per N cycles upstream.
//   - Ordering: vectors leave in acceptance order. Elements leave in index order 0..N-1.
//   - No arithmetic on data; values pass through bit-exact.
// TESTING
//   1 Reset, then in_vec={16'h0004,16'h0003,16'h0002,16'h0001}, m_ready=1 ->
//     data_out 1,2,3,4 on 4 consecutive cycles starting 1 cycle after accept;
//     m_last=1 only with 4.
//   2 Two vectors accepted on consecutive edges, m_ready=0 -> in_ready=0 after the 2nd.
//     Release m_ready -> 8 elements with no gap, in order.
//   3 Set m_ready randomly 50%, 200 random vectors including -32768 and 32767 ->
//     output matches a scoreboard bit-exact; data_out/m_last stable whenever
//     m_valid=1 & m_ready=0.
//   4 In TWO state, hold in_valid=1 while the final element of the head vector is sent ->
//     in_ready=0 on that edge and 1 the next cycle; the new vector loads with no loss
//     or duplication.
//   5 Assert reset_n=0 asynchronously (between edges) after element 1 of a vector ->
//     m_valid=0 and data_out=0 immediately. After release, a new vector starts at element 0.
//   6 Continuous in_valid=1, m_ready=1 for 100 vectors -> in_ready duty 1/N;
//     m_valid stays 1 from the first element to the last.

Source files
------------

// File: rtl/vec_stream_serializer.sv
// ---------------------------------------------------------------------------
// vec_stream_serializer
//   Transmit side of the layer input stream. Accepts one N-element signed
//   vector per handshake on a parallel port and emits its elements one per
//   handshake, element 0 first, on a valid/ready serial stream.
//   Two vector slots are used ping-pong. The next vector loads into one slot
//   while the other slot drains, so a consumer that is always ready sees no
//   bubbles between vectors.
//
// Parameters
//   T  element width in bits (signed)
//   N  elements per vector
//
// Ports
//   clk       in   1    clock; all state updates on posedge
//   reset_n   in   1    asynchronous active-low reset
//   in_valid  in   1    producer has a vector on in_vec
//   in_ready  out  1    block can accept a vector this cycle
//   in_vec    in   N*T  vector; element k = in_vec[k*T +: T]
//   m_valid   out  1    data_out holds a valid element
//   m_ready   in   1    downstream accepts the element
//   data_out  out  T    current element (0 when m_valid=0)
//   m_last    out  1    current element is element N-1 of its vector
// ---------------------------------------------------------------------------
module vec_stream_serializer #(
  parameter int T = 16,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*T-1:0]      in_vec,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic                m_last
);

  localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Occupancy (EMPTY / ONE / TWO) is the population count of full_q; the
  // per-slot flags are the state, so no separate encoding is kept.
  logic [N*T-1:0]   slot_q [2];
  logic [1:0]       full_q,   full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] idx_q,    idx_d;

  logic             accept;
  logic             send;
  logic             at_last;
  logic [N*T-1:0]   rd_vec;

  // ---------------------------------------------------------------------
  // Output decode: everything comes from registers. in_ready is also held
  // low while reset is asserted, because the cleared full flags alone would
  // otherwise advertise an empty slot during reset.
  // ---------------------------------------------------------------------
  assign in_ready = reset_n & ~full_q[wr_sel_q];
  assign m_valid  = full_q[rd_sel_q];
  assign at_last  = (idx_q == LAST_IDX);
  assign m_last   = m_valid & at_last;
  assign rd_vec   = slot_q[rd_sel_q];
  assign data_out = m_valid ? rd_vec[idx_q*T +: T] : '0;

  assign accept = in_valid & in_ready;
  assign send   = m_valid & m_ready;

  // ---------------------------------------------------------------------
  // Next-state logic. An accept and a final-element send on the same edge
  // always touch different slots (accept needs full[wr_sel]=0, send needs
  // full[rd_sel]=1), so both updates can be applied independently.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;

    if (accept) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (send) begin
      if (at_last) begin
        idx_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control state. A reset mid-vector simply clears the flags and pointers,
  // which discards whatever was partially sent.
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Vector storage. in_vec is captured only on an accepting edge.
  // ---------------------------------------------------------------------
  // NOTE: the slot storage has no reset; the full flags gate every read,
  // so stale contents are never visible on data_out.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_q[wr_sel_q] <= in_vec;
    end
  end

endmodule

// File: tb/tb_vec_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_vec_stream_serializer
//   Directed and randomised stimulus for vec_stream_serializer (T=16, N=4).
//   Inputs change 1 ns after a rising edge; handshakes are evaluated from the
//   values present just before the next edge. A scoreboard of expected
//   elements is filled from the vectors the bench itself presented.
// ---------------------------------------------------------------------------
module tb_vec_stream_serializer;

  localparam int T = 16;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*T-1:0] in_vec;
  logic           m_valid;
  logic           m_ready;
  logic [T-1:0]   data_out;
  logic           m_last;

  vec_stream_serializer #(.T(T), .N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .m_last   (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [T-1:0] data;
    logic         last;
  } elem_t;

  elem_t sb_q[$];
  int    n_tests;
  int    n_fail;
  logic  last_acc;
  logic  last_snd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: score the handshakes that will fire on the coming edge,
  // advance, and verify that a stalled element did not change.
  task automatic tick();
    logic  acc, snd, hold, hold_l;
    logic [T-1:0] hold_d;
    elem_t e;
    acc    = in_valid && in_ready;
    snd    = m_valid && m_ready;
    hold   = m_valid && !m_ready;
    hold_d = data_out;
    hold_l = m_last;
    if (snd) begin
      if (sb_q.size() == 0) begin
        check("unexpected_elem", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", {16'd0, data_out}, {16'd0, e.data});
        check("sb_last", {31'd0, m_last}, {31'd0, e.last});
      end
    end
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        e.data = in_vec[k*T +: T];
        e.last = (k == N - 1);
        sb_q.push_back(e);
      end
    end
    last_acc = acc;
    last_snd = snd;
    @(posedge clk);
    #1;
    if (hold && reset_n) begin
      check("hold_data", {16'd0, data_out}, {16'd0, hold_d});
      check("hold_last", {31'd0, m_last}, {31'd0, hold_l});
    end
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*T-1:0] gen_vec();
    logic [N*T-1:0] v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*T +: T] = 16'h8000;
        1:       v[k*T +: T] = 16'h7FFF;
        default: v[k*T +: T] = 16'($urandom());
      endcase
    end
    return v;
  endfunction

  initial begin
    logic [T-1:0]   exp2 [8];
    logic [N*T-1:0] pend;
    logic           have;
    int             vec_sent, budget, gaps, bad_space, sends, prev_acc, acc_cnt, cyc;
    logic           started;

    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    in_vec   = '0;

    // ---- Reset state ----
    #2;
    check("rst_m_valid",  {31'd0, m_valid},  32'd0);
    check("rst_m_last",   {31'd0, m_last},   32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- 1: single vector, consumer always ready ----
    in_vec   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    m_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_m_valid", {31'd0, m_valid}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t1_data", {16'd0, data_out}, 32'(i));
      check("t1_last", {31'd0, m_last}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("t1_idle", {31'd0, m_valid}, 32'd0);
    check("t1_idle_data", {16'd0, data_out}, 32'd0);

    // ---- 2: two vectors stalled, then a gapless drain ----
    m_ready  = 1'b0;
    in_valid = 1'b1;
    in_vec   = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
    tick();
    in_vec   = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
    tick();
    in_valid = 1'b0;
    check("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("t2_head", {16'd0, data_out}, 32'h11);
    exp2 = '{16'h11, 16'h12, 16'h13, 16'h14, 16'h21, 16'h22, 16'h23, 16'h24};
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_no_gap", {31'd0, m_valid}, 32'd1);
      check("t2_order", {16'd0, data_out}, {16'd0, exp2[i]});
      tick();
    end
    check("t2_drained", {31'd0, m_valid}, 32'd0);

    // ---- 4: TWO state, accept attempted while the head's last element leaves ----
    m_ready  = 1'b0;
    in_valid = 1'b1;
    in_vec   = {16'h0034, 16'h0033, 16'h0032, 16'h0031};
    tick();
    in_vec   = {16'h0044, 16'h0043, 16'h0042, 16'h0041};
    tick();
    in_vec   = {16'h0054, 16'h0053, 16'h0052, 16'h0051};
    m_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      check("t4_in_ready_two", {31'd0, in_ready}, 32'd0);
      tick();
      check("t4_no_accept", {31'd0, last_acc}, 32'd0);
    end
    check("t4_in_ready_freed", {31'd0, in_ready}, 32'd1);
    tick();
    check("t4_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    budget = 0;
    while (sb_q.size() != 0 && budget < 40) begin
      tick();
      budget++;
    end
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    check("t4_idle", {31'd0, m_valid}, 32'd0);

    // ---- 5: asynchronous reset mid-vector ----
    in_vec   = {16'h0064, 16'h0063, 16'h0062, 16'h0061};
    in_valid = 1'b1;
    m_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t5_mid_elem", {16'd0, data_out}, 32'h63);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_m_valid", {31'd0, m_valid},  32'd0);
    check("t5_rst_data",    {16'd0, data_out}, 32'd0);
    check("t5_rst_m_last",  {31'd0, m_last},   32'd0);
    sb_q.delete();
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    in_vec   = {16'h0074, 16'h0073, 16'h0072, 16'h0071};
    in_valid = 1'b1;
    m_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_restart_elem0", {16'd0, data_out}, 32'h71);
    repeat (N) tick();
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- 3: random back-pressure, 200 random vectors incl. extreme values ----
    vec_sent = 0;
    have     = 1'b0;
    pend     = '0;
    budget   = 0;
    while ((vec_sent < 200 || sb_q.size() != 0) && budget < 5000) begin
      if (!have && vec_sent < 200) begin
        pend = (vec_sent == 0) ? {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000} : gen_vec();
        have = 1'b1;
      end
      in_valid = have && ($urandom_range(0, 3) != 0);
      in_vec   = pend;
      m_ready  = $urandom_range(0, 1) != 0;
      tick();
      if (last_acc) begin
        have = 1'b0;
        vec_sent++;
      end
      budget++;
    end
    in_valid = 1'b0;
    check("t3_vectors_sent", 32'(vec_sent), 32'd200);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- 6: continuous streaming, 100 vectors ----
    in_valid  = 1'b1;
    m_ready   = 1'b1;
    in_vec    = gen_vec();
    acc_cnt   = 0;
    sends     = 0;
    gaps      = 0;
    bad_space = 0;
    prev_acc  = -1;
    started   = 1'b0;
    cyc       = 0;
    while (sends < 100 * N && cyc < 2000) begin
      in_valid = (acc_cnt < 100);
      if (m_valid) started = 1'b1;
      if (started && !m_valid) gaps++;
      tick();
      if (last_snd) sends++;
      if (last_acc) begin
        // Steady state: after the two initial loads, one accept every N cycles.
        if (acc_cnt >= 2 && (cyc - prev_acc) != N) bad_space++;
        prev_acc = cyc;
        acc_cnt++;
        in_vec = gen_vec();
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("t6_accepts", 32'(acc_cnt), 32'd100);
    check("t6_sends", 32'(sends), 32'(100 * N));
    check("t6_gaps", 32'(gaps), 32'd0);
    check("t6_accept_spacing", 32'(bad_space), 32'd0);
    check("t6_drain_cycles", 32'(cyc), 32'(100 * N + 1));
    check("t6_idle", {31'd0, m_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
